fft_sdf_feed: RTL

- Radix-2 single-delay-feedback (R2SDF) stage controller for the 16-point fixed-point FFT.
- Sits directly upstream of the combinational butterfly, which computes (a-c)·W on the real/imag pair.
- Buffers the first half of each 2·DEPTH-sample frame, presents butterfly operands and the twiddle factor, and emits the sum path.
- Stores the twiddled difference products from the butterfly and drains them to the next stage.

---
 rtl/fft_sdf_feed.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fft_sdf_feed.sv
// ---------------------------------------------------------------------------
// fft_sdf_feed
// Radix-2 single-delay-feedback stage controller. Buffers the first half of a
// 2*DEPTH-sample frame, presents butterfly operands plus twiddle W^k to an
// external combinational butterfly, emits the sum path x[j]+x[j+DEPTH], then
// drains the stored difference products (x[j]-x[j+DEPTH])*W^k.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready low while draining)
//   in_real, in_img          input sample, signed Q16.16
//   bf_a, bf_b               buffer head real/img (x[j])
//   bf_c, bf_d               input sample pass-through (x[j+DEPTH])
//   bf_wr, bf_wi             twiddle W^k, Q16.16
//   bf_o_real, bf_o_img      butterfly product returned for storage
//   out_valid, out_real,
//   out_img, out_last        registered output sample, last-of-frame flag
//
// Parameter DEPTH: half-frame length, one of 1, 2, 4, 8 (twiddle stride 8/DEPTH).
// Build option SDF_SAT_EN: when defined, the sum path saturates instead of
// wrapping (real and imaginary parts independently).
// ---------------------------------------------------------------------------
module fft_sdf_feed #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_real,
   input  logic [31:0] in_img,
   output logic [31:0] bf_a,
   output logic [31:0] bf_b,
   output logic [31:0] bf_c,
   output logic [31:0] bf_d,
   output logic [31:0] bf_wr,
   output logic [31:0] bf_wi,
   input  logic [31:0] bf_o_real,
   input  logic [31:0] bf_o_img,
   output logic        out_valid,
   output logic [31:0] out_real,
   output logic [31:0] out_img,
   output logic        out_last
);

   typedef enum logic [1:0] {FILL, BFLY, DRAIN} state_t;

   localparam logic [3:0] JLAST  = 4'(DEPTH - 1);
   localparam logic [3:0] STRIDE = 4'(8 / DEPTH);

   state_t      state;
   logic [3:0]  j;
   logic [63:0] dbuf [DEPTH];   // {real, img}; index 0 is the head
   logic [63:0] tail_in;
   logic [2:0]  k;
   logic        accept;
   logic        shift_en;

   // Sum path: wraps by default, saturates when SDF_SAT_EN is defined.
   function automatic logic [31:0] add_q(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] s;
      s = a + b;
`ifdef SDF_SAT_EN
      if ((a[31] == b[31]) && (s[31] != a[31]))
         s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
      // wrap-around is the natural result of the 32-bit add
`endif
      return s;
   endfunction

   assign in_ready = (state != DRAIN);
   assign accept   = in_valid && in_ready;
   // Every push (fill, product store, drain) is the same shift toward the head.
   assign shift_en = accept || (state == DRAIN);

   assign bf_a = dbuf[0][63:32];
   assign bf_b = dbuf[0][31:0];
   assign bf_c = in_real;
   assign bf_d = in_img;

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      tail_in = '0;
      case (state)
         FILL:    tail_in = {in_real, in_img};
         BFLY:    tail_in = {bf_o_real, bf_o_img};
         default: tail_in = '0;
      endcase
   end

   // Twiddle index; held at k=0 outside BFLY.
   always_comb begin
      k = 3'd0;
      if (state == BFLY)
         k = 3'(j * STRIDE);
   end

   always_comb begin
      bf_wr = 32'h0001_0000;
      bf_wi = 32'h0000_0000;
      case (k)
         3'd0: begin bf_wr = 32'h0001_0000; bf_wi = 32'h0000_0000; end
         3'd1: begin bf_wr = 32'h0000_EC83; bf_wi = 32'hFFFF_9E08; end
         3'd2: begin bf_wr = 32'h0000_B505; bf_wi = 32'hFFFF_4AFB; end
         3'd3: begin bf_wr = 32'h0000_61F8; bf_wi = 32'hFFFF_137D; end
         3'd4: begin bf_wr = 32'h0000_0000; bf_wi = 32'hFFFF_0000; end
         3'd5: begin bf_wr = 32'hFFFF_9E08; bf_wi = 32'hFFFF_137D; end
         3'd6: begin bf_wr = 32'hFFFF_4AFB; bf_wi = 32'hFFFF_4AFB; end
         3'd7: begin bf_wr = 32'hFFFF_137D; bf_wi = 32'hFFFF_9E08; end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         j         <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_real  <= '0;
         out_img   <= '0;
         // NOTE: the delay buffer is a register shift chain, so it can be cleared on reset like any other flop.
         for (int i = 0; i < DEPTH; i++)
            dbuf[i] <= '0;
      end else begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;

         if (shift_en) begin
            for (int i = 0; i < DEPTH - 1; i++)
               dbuf[i] <= dbuf[i + 1];
            dbuf[DEPTH - 1] <= tail_in;
         end

         case (state)
            FILL: begin
               if (accept) begin
                  if (j == JLAST) begin
                     state <= BFLY;
                     j     <= '0;
                  end else begin
                     j <= j + 4'd1;
                  end
               end
            end
            BFLY: begin
               if (accept) begin
                  out_valid <= 1'b1;
                  out_real  <= add_q(dbuf[0][63:32], in_real);
                  out_img   <= add_q(dbuf[0][31:0], in_img);
                  if (j == JLAST) begin
                     state <= DRAIN;
                     j     <= '0;
                  end else begin
                     j <= j + 4'd1;
                  end
               end
            end
            default: begin   // DRAIN
               out_valid <= 1'b1;
               out_real  <= dbuf[0][63:32];
               out_img   <= dbuf[0][31:0];
               if (j == JLAST) begin
                  out_last <= 1'b1;
                  state    <= FILL;
                  j        <= '0;
               end else begin
                  j <= j + 4'd1;
               end
            end
         endcase
      end
   end

endmodule
